// File: rtl/mapper_pkg.sv
// Shared types and mapping helpers for enum_lane_mapper.
package mapper_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_SWAP = 2'd1,
    MODE_INC  = 2'd2,
    MODE_DEC  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_t;

  // Codes are carried at 8 bits (max 256 codes) and computed at 9 bits so
  // c+1 never overflows before reduction.
  function automatic logic [7:0] map_code(input logic [7:0]  code,
                                          input mode_t       mode,
                                          input int unsigned num_codes);
    logic [8:0] c;
    logic [8:0] n;
    logic [8:0] r;
    c = {1'b0, code};
    n = 9'(num_codes);
    r = c;
    if (c < n) begin
      unique case (mode)
        MODE_HOLD: r = c;
        MODE_SWAP: begin
          if (c[0])                 r = c - 9'd1;
          else if (c + 9'd1 < n)    r = c + 9'd1;
          else                      r = c;
        end
        MODE_INC:  r = (c + 9'd1 == n) ? '0 : c + 9'd1;
        MODE_DEC:  r = (c == '0) ? n - 9'd1 : c - 9'd1;
        default:   r = c;
      endcase
    end
    return 8'(r);
  endfunction

  function automatic logic code_err(input logic [7:0]  code,
                                    input int unsigned num_codes);
    return {1'b0, code} >= 9'(num_codes);
  endfunction

endpackage

// File: rtl/enum_lane_fifo2.sv
// Generic 2-entry valid/ready buffer; in_ready depends only on registered state.
module enum_lane_fifo2
  import mapper_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  fifo_state_t      state_q, state_d;
  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic             push;
  logic             pop;

  assign in_ready  = (state_q != FIFO_FULL);
  assign out_valid = (state_q != FIFO_EMPTY);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FIFO_EMPTY: if (push) state_d = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      state_d = FIFO_FULL;
        else if (pop && !push) state_d = FIFO_EMPTY;
      end
      FIFO_FULL:  if (pop)  state_d = FIFO_ONE;
      default:    state_d = FIFO_EMPTY;
    endcase
  end

  // State, pointers and storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FIFO_EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: rtl/enum_lane_mapper.sv
// Per-lane enum code mapper feeding a 2-entry output buffer.
module enum_lane_mapper
  import mapper_pkg::*;
#(
  parameter int unsigned NUM_CODES = 2,
  parameter int unsigned LANES     = 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [1:0]                                      in_mode,
  input  logic [LANES*((NUM_CODES > 2) ? $clog2(NUM_CODES) : 1)-1:0] in_code,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [LANES*((NUM_CODES > 2) ? $clog2(NUM_CODES) : 1)-1:0] out_code,
  output logic [LANES-1:0]                                out_err,
  output logic [15:0]                                     beat_count
);

  localparam int unsigned CODE_W = (NUM_CODES > 2) ? $clog2(NUM_CODES) : 1;
  localparam int unsigned ENT_W  = CODE_W + 1;

  mode_t                    mode;
  logic [LANES*ENT_W-1:0]   fifo_in;
  logic [LANES*ENT_W-1:0]   fifo_out;
  logic [15:0]              beat_count_q;

  assign mode       = mode_t'(in_mode);
  assign beat_count = beat_count_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] code_ext;
    assign code_ext = 8'(in_code[g*CODE_W +: CODE_W]);
    assign fifo_in[g*ENT_W +: ENT_W] =
      {code_err(code_ext, NUM_CODES), CODE_W'(map_code(code_ext, mode, NUM_CODES))};
    assign out_code[g*CODE_W +: CODE_W] = fifo_out[g*ENT_W +: CODE_W];
    assign out_err[g]                   = fifo_out[g*ENT_W + CODE_W];
  end

  enum_lane_fifo2 #(
    .WIDTH(LANES*ENT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (fifo_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (fifo_out)
  );

  // Accepted-beat counter, wraps silently
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count_q <= '0;
    end else if (in_valid && in_ready) begin
      beat_count_q <= beat_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_enum_lane_mapper.sv
module tb_enum_lane_mapper;
  import mapper_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: NUM_CODES=5, LANES=4 (CODE_W=3)
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0]  a_in_mode;
  logic [11:0] a_in_code, a_out_code;
  logic [3:0]  a_out_err;
  logic [15:0] a_beat_count;

  enum_lane_mapper #(.NUM_CODES(5), .LANES(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_code(a_in_code),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_code(a_out_code),
    .out_err(a_out_err), .beat_count(a_beat_count)
  );

  // DUT B: NUM_CODES=2, LANES=1
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]  b_in_mode;
  logic [0:0]  b_in_code, b_out_code, b_out_err;
  logic [15:0] b_beat_count;

  enum_lane_mapper #(.NUM_CODES(2), .LANES(1)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_code(b_in_code),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_code(b_out_code),
    .out_err(b_out_err), .beat_count(b_beat_count)
  );

  typedef struct packed {
    logic [11:0] code;
    logic [3:0]  err;
  } a_exp_t;

  a_exp_t     a_q[$];
  logic [1:0] b_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] p4(input int unsigned l0, input int unsigned l1,
                                     input int unsigned l2, input int unsigned l3);
    return {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (a_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_beat: got code %0h err %0h, expected no beat", a_out_code, a_out_err);
      end else begin
        a_exp_t e;
        e = a_q.pop_front();
        check("a_code", 32'(a_out_code), 32'(e.code));
        check("a_err",  32'(a_out_err),  32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (b_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_beat: got code %0h, expected no beat", b_out_code);
      end else begin
        logic [1:0] e;
        e = b_q.pop_front();
        check("b_code", 32'(b_out_code), 32'(e[0]));
        check("b_err",  32'(b_out_err),  32'(e[1]));
      end
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a beat; queue its expectation on the cycle it is accepted.
  task automatic send_a(input logic [1:0] mode, input logic [11:0] code,
                        input logic [11:0] ecode, input logic [3:0] eerr);
    a_in_valid = 1'b1;
    a_in_mode  = mode;
    a_in_code  = code;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_in_ready && !rst) begin
        a_q.push_back('{code: ecode, err: eerr});
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL a_send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] mode, input logic code, input logic ecode);
    b_in_valid = 1'b1;
    b_in_mode  = mode;
    b_in_code  = code;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_in_ready && !rst) begin
        b_q.push_back({1'b0, ecode});
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL b_send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_q.size() == 0 && !a_out_valid) break;
    end
    check("a_drain", 32'(a_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    cycles(2);
    a_q.delete();
    b_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_mode = 2'd0; a_in_code = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_mode = 2'd0; b_in_code = '0; b_out_ready = 1'b1;
    cycles(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid",  32'(a_out_valid),  32'd0);
    check("rst_in_ready",   32'(a_in_ready),   32'd1);
    check("rst_beat_count", 32'(a_beat_count), 32'd0);
    check("rst_out_code",   32'(a_out_code),   32'd0);
    check("rst_out_err",    32'(a_out_err),    32'd0);
    check("rst_b_valid",    32'(b_out_valid),  32'd0);
    @(posedge clk);
    #1;

    // NUM_CODES=2 swap, one-cycle latency
    send_b(MODE_SWAP, 1'b0, 1'b1);
    @(negedge clk);
    check("b_latency0", 32'(b_out_valid), 32'd1);
    @(posedge clk);
    #1;
    send_b(MODE_SWAP, 1'b1, 1'b0);
    @(negedge clk);
    check("b_latency1", 32'(b_out_valid), 32'd1);
    @(posedge clk);
    #1;
    send_b(MODE_INC,  1'b1, 1'b0);
    send_b(MODE_DEC,  1'b0, 1'b1);
    send_b(MODE_HOLD, 1'b1, 1'b1);
    cycles(3);
    check("b_count", 32'(b_beat_count), 32'd5);

    // NUM_CODES=5, LANES=4, back-to-back
    send_a(MODE_INC,  p4(4,3,0,7), p4(0,4,1,7), 4'b1000);
    send_a(MODE_DEC,  p4(4,3,0,7), p4(3,2,4,7), 4'b1000);
    send_a(MODE_SWAP, p4(4,3,0,7), p4(4,2,1,7), 4'b1000);
    send_a(MODE_HOLD, p4(4,3,0,7), p4(4,3,0,7), 4'b1000);
    send_a(MODE_INC,  p4(1,2,6,5), p4(2,3,6,5), 4'b1100);
    send_a(MODE_DEC,  p4(0,1,2,3), p4(4,0,1,2), 4'b0000);
    send_a(MODE_SWAP, p4(0,1,2,3), p4(1,0,3,2), 4'b0000);
    drain_a();
    check("a_count7", 32'(a_beat_count), 32'd7);

    // Backpressure: A, B accepted, C held until out_ready rises
    do_reset();
    a_out_ready = 1'b0;
    send_a(MODE_HOLD, p4(1,1,1,1), p4(1,1,1,1), 4'b0000);
    send_a(MODE_INC,  p4(2,2,2,2), p4(3,3,3,3), 4'b0000);
    a_in_valid = 1'b1;
    a_in_mode  = MODE_DEC;
    a_in_code  = p4(0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(a_in_ready),   32'd0);
      check("bp_count",    32'(a_beat_count), 32'd2);
      check("bp_head",     32'(a_out_code),   32'(p4(1,1,1,1)));
      @(posedge clk);
      #1;
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_full_pop_ready", 32'(a_in_ready), 32'd0);
    @(posedge clk);
    #1;
    send_a(MODE_DEC, p4(0,0,0,0), p4(4,4,4,4), 4'b0000);
    drain_a();
    check("bp_count3", 32'(a_beat_count), 32'd3);

    // Sustained push+pop in ONE for 10 beats
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send_a(MODE_HOLD, p4(i % 5, (i+1) % 5, (i+2) % 5, (i+3) % 5),
                            p4(i % 5, (i+1) % 5, (i+2) % 5, (i+3) % 5), 4'b0000);
        end
      end
      begin
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
          @(negedge clk);
          check("one_out_valid", 32'(a_out_valid), 32'd1);
          check("one_in_ready",  32'(a_in_ready),  32'd1);
        end
      end
    join
    drain_a();
    check("one_count13", 32'(a_beat_count), 32'd13);

    // Reset while FULL, with a beat offered during reset
    a_out_ready = 1'b0;
    send_a(MODE_INC, p4(1,2,3,4), p4(2,3,4,0), 4'b0000);
    send_a(MODE_DEC, p4(1,2,3,4), p4(0,1,2,3), 4'b0000);
    @(negedge clk);
    check("rf_full", 32'(a_in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    a_in_valid = 1'b1;
    a_in_mode  = MODE_SWAP;
    a_in_code  = p4(3,3,3,3);
    cycles(1);
    a_q.delete();
    rst        = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("rf_out_valid",  32'(a_out_valid),  32'd0);
    check("rf_in_ready",   32'(a_in_ready),   32'd1);
    check("rf_beat_count", 32'(a_beat_count), 32'd0);
    check("rf_out_code",   32'(a_out_code),   32'd0);
    check("rf_out_err",    32'(a_out_err),    32'd0);
    a_out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rf_no_stale", 32'(a_out_valid), 32'd0);
    @(posedge clk);
    #1;

    // beat_count wrap
    for (int i = 0; i < 65535; i++) begin
      send_a(MODE_HOLD, p4(0,0,0,0), p4(0,0,0,0), 4'b0000);
    end
    @(negedge clk);
    check("wrap_ffff", 32'(a_beat_count), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    send_a(MODE_SWAP, p4(2,4,6,1), p4(3,4,6,0), 4'b0100);
    @(negedge clk);
    check("wrap_zero", 32'(a_beat_count), 32'd0);
    @(posedge clk);
    #1;
    drain_a();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
